// File: rtl/led_pkg.sv
// Shared defaults and level type for the LED trail PWM stage.
package led_pkg;

  localparam int unsigned DEF_N_LEDS    = 14;
  localparam int unsigned DEF_LEVEL_W   = 4;
  localparam int unsigned DEF_DECAY_DIV = 2;
  localparam int unsigned MAX_LEVEL     = (1 << DEF_LEVEL_W) - 1;

  typedef logic [DEF_LEVEL_W-1:0] level_t;

endpackage

// File: rtl/led_trail_cell.sv
// One LED: brightness level register plus registered PWM compare.
module led_trail_cell
  import led_pkg::*;
#(
  parameter int unsigned LEVEL_W = DEF_LEVEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set,
  input  logic               decay,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               led
);

  localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

  logic [LEVEL_W-1:0] level_d, level_q;
  logic               led_d, led_q;

  // Level update (set beats decay, decay saturates at 0) and duty compare
  always_comb begin
    level_d = level_q;
    led_d   = (level_q == LVL_MAX) || (level_q > pwm_cnt);
    if (set) begin
      level_d = LVL_MAX;
    end else if (decay && (level_q != '0)) begin
      level_d = level_q - LEVEL_W'(1);
    end
  end

  // Level and drive registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_trail_pwm.sv
// Drives LEDs from the pattern stream: set bits solid, dropped bits fade out via PWM.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS    = DEF_N_LEDS,
  parameter int unsigned LEVEL_W   = DEF_LEVEL_W,
  parameter int unsigned DECAY_DIV = DEF_DECAY_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pat_valid,
  input  logic [N_LEDS-1:0] pat_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              frame_tick
);

  localparam int unsigned        DEC_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [LEVEL_W-1:0] PWM_MAX  = '1;
  localparam logic [DEC_W-1:0]   DEC_LAST = DEC_W'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]  pat_d, pat_q;
  logic [LEVEL_W-1:0] pwm_cnt_d, pwm_cnt_q;
  logic [DEC_W-1:0]   dec_cnt_d, dec_cnt_q;
  logic               frame_tick_d, frame_tick_q;
  logic [N_LEDS-1:0]  eff_pat_c;
  logic               frame_end_c;
  logic               decay_c;

  // Frame/decay timing and effective pattern (a fresh strobe overrides the latch)
  always_comb begin
    frame_end_c  = (pwm_cnt_q == PWM_MAX);
    decay_c      = frame_end_c && (dec_cnt_q == DEC_LAST);
    eff_pat_c    = pat_valid ? pat_in : pat_q;
    pat_d        = eff_pat_c;
    pwm_cnt_d    = pwm_cnt_q + LEVEL_W'(1);
    frame_tick_d = frame_end_c;
    dec_cnt_d    = dec_cnt_q;
    if (frame_end_c) begin
      dec_cnt_d = decay_c ? '0 : dec_cnt_q + DEC_W'(1);
    end
  end

  // Shared state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q        <= '0;
      pwm_cnt_q    <= '0;
      dec_cnt_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      pat_q        <= pat_d;
      pwm_cnt_q    <= pwm_cnt_d;
      dec_cnt_q    <= dec_cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame_tick = frame_tick_q;

  for (genvar i = 0; i < int'(N_LEDS); i++) begin : g_cell
    led_trail_cell #(
      .LEVEL_W (LEVEL_W)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (eff_pat_c[i]),
      .decay   (decay_c),
      .pwm_cnt (pwm_cnt_q),
      .led     (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: cycle scoreboard plus directed and table-driven checks.
module tb_led_trail_pwm;

  localparam int NL = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pat_valid;
  logic [NL-1:0] pat_in;
  logic [NL-1:0] led_out;
  logic          frame_tick;

  always #5 clk = ~clk;

  led_trail_pwm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pat_valid  (pat_valid),
    .pat_in     (pat_in),
    .led_out    (led_out),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [NL-1:0] led;
    logic          tick;
  } exp_t;

  typedef struct packed {
    logic [NL-1:0] pat;
    logic [NL-1:0] imm;
    logic [NL-1:0] settled;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   e        = 0;

  // Reference model state: levels 0..15, 16-cycle frame, decay every 2nd frame
  int            m_lvl[NL];
  int            m_pwm;
  int            m_dec;
  logic [NL-1:0] m_pat;

  function automatic logic [NL-1:0] model_led();
    logic [NL-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i] = (m_lvl[i] == 15) || (m_pwm < m_lvl[i]);
    return r;
  endfunction

  function automatic logic [NL-1:0] model_eff();
    return pat_valid ? pat_in : m_pat;
  endfunction

  function automatic logic model_decay();
    return (m_pwm == 15) && (m_dec == 1);
  endfunction

  // Model advances on each edge and queues the output expected after it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pwm <= 0;
      m_dec <= 0;
      m_pat <= '0;
      for (int i = 0; i < NL; i++) m_lvl[i] <= 0;
      sb.delete();
    end else begin
      sb.push_back('{led: model_led(), tick: (m_pwm == 15)});
      if (pat_valid) m_pat <= pat_in;
      m_pwm <= (m_pwm + 1) % 16;
      if (m_pwm == 15) m_dec <= (m_dec == 1) ? 0 : m_dec + 1;
      for (int i = 0; i < NL; i++) begin
        if (model_eff()[i]) m_lvl[i] <= 15;
        else if (model_decay() && m_lvl[i] > 0) m_lvl[i] <= m_lvl[i] - 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Advance n edges, sampling 1ns after each and draining the scoreboard
  task automatic step(input int n);
    exp_t x;
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("sb_led", int'(led_out), int'(x.led));
        check("sb_tick", int'(frame_tick), int'(x.tick));
      end
    end
  endtask

  task automatic strobe(input logic [NL-1:0] p);
    pat_valid = 1'b1;
    pat_in    = p;
    step(1);
    pat_valid = 1'b0;
    pat_in    = '0;
  endtask

  task automatic reset_dut();
    pat_valid = 1'b0;
    pat_in    = '0;
    rst_n     = 1'b0;
    step(2);
    rst_n = 1'b1;
    e     = 0;
  endtask

  // Wait until just after a frame wrap so the next edge is not a decay step
  task automatic align_frame();
    int k;
    k = 0;
    while (!frame_tick && k < 64) begin
      step(1);
      k++;
    end
    check("align_tick", int'(frame_tick), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   cnt, cnt13, bad, ticks, first;

    vecs[0] = '{pat: 14'h0001, imm: 14'h0001, settled: 14'h0001};
    vecs[1] = '{pat: 14'h0000, imm: 14'h0001, settled: 14'h0000};
    vecs[2] = '{pat: 14'h2AAA, imm: 14'h2AAA, settled: 14'h2AAA};
    vecs[3] = '{pat: 14'h1555, imm: 14'h3FFF, settled: 14'h1555};
    vecs[4] = '{pat: 14'h3FFF, imm: 14'h3FFF, settled: 14'h3FFF};
    vecs[5] = '{pat: 14'h2000, imm: 14'h3FFF, settled: 14'h2000};
    vecs[6] = '{pat: 14'h0000, imm: 14'h2000, settled: 14'h0000};

    pat_valid = 1'b0;
    pat_in    = '0;
    rst_n     = 1'b0;

    // Solid LED for 1000 cycles, one-edge output latency
    reset_dut();
    check("reset_led", int'(led_out), 0);
    check("reset_tick", int'(frame_tick), 0);
    strobe(14'h0001);
    check("latency_edge_k", int'(led_out), 0);
    step(1);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (led_out !== 14'h0001) bad++;
      step(1);
    end
    check("solid_1000", bad, 0);

    // Full fade of LED 0
    reset_dut();
    strobe(14'h0001);
    strobe(14'h0000);
    check("after_clear", int'(led_out), 1);
    step(14);
    cnt = 0;
    repeat (16) begin step(1); cnt += int'(led_out[0]); end
    check("no_decay_first_tick", cnt, 16);
    cnt = 0;
    repeat (16) begin step(1); cnt += int'(led_out[0]); end
    check("duty_14", cnt, 14);
    step(416);
    cnt = 0;
    repeat (16) begin step(1); cnt += int'(led_out[0]); end
    check("duty_1", cnt, 1);
    bad = 0;
    repeat (120) begin step(1); if (led_out !== '0) bad++; end
    check("fade_done", bad, 0);

    // Strobe on a decay-step edge: set and decrement together
    reset_dut();
    strobe(14'h0001);
    strobe(14'h0000);
    step(318);
    cnt = 0;
    repeat (16) begin step(1); cnt += int'(led_out[0]); end
    check("duty_5", cnt, 5);
    step(15);
    strobe(14'h2000);
    cnt = 0;
    cnt13 = 0;
    repeat (16) begin
      step(1);
      cnt   += int'(led_out[0]);
      cnt13 += int'(led_out[13]);
    end
    check("coincide_duty_4", cnt, 4);
    check("coincide_bit13", cnt13, 16);

    // Retrigger a fading LED, then reset mid-operation without a clock edge
    reset_dut();
    strobe(14'h0008);
    strobe(14'h0000);
    step(386);
    check("fading_low", int'(led_out[3]), 0);
    step(1);
    strobe(14'h0008);
    cnt = 0;
    repeat (16) begin step(1); cnt += int'(led_out[3]); end
    check("retrigger_solid", cnt, 16);
    step(10);
    check("pre_reset_tick", int'(frame_tick), 1);
    check("pre_reset_led", int'(led_out), 14'h0008);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", int'(led_out), 0);
    check("async_reset_tick", int'(frame_tick), 0);
    step(2);
    rst_n = 1'b1;
    e     = 0;
    first = -1;
    bad   = 0;
    repeat (100) begin
      step(1);
      if (frame_tick && first < 0) first = e;
      if (led_out !== '0) bad++;
    end
    check("first_tick", first, 16);
    check("off_after_reset", bad, 0);

    // frame_tick: single-cycle pulses every 16 cycles over 100 frames
    reset_dut();
    bad   = 0;
    ticks = 0;
    repeat (1600) begin
      step(1);
      if (int'(frame_tick) != int'(e % 16 == 0)) bad++;
      ticks += int'(frame_tick);
    end
    check("tick_pattern", bad, 0);
    check("tick_count", ticks, 100);

    // Pattern table: immediate output after a strobe and after fade settles
    reset_dut();
    for (int v = 0; v < 7; v++) begin
      align_frame();
      strobe(vecs[v].pat);
      step(1);
      check($sformatf("vec%0d_imm", v), int'(led_out), int'(vecs[v].imm));
      step(520);
      check($sformatf("vec%0d_settled", v), int'(led_out), int'(vecs[v].settled));
    end

    // Back-to-back strobes: last one latched, first one leaves a trail
    align_frame();
    pat_valid = 1'b1;
    pat_in    = 14'h00F0;
    step(1);
    pat_in = 14'h000F;
    step(1);
    pat_valid = 1'b0;
    pat_in    = '0;
    step(1);
    check("b2b_imm", int'(led_out), 14'h00FF);
    step(520);
    check("b2b_settled", int'(led_out), 14'h000F);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
